// File: rtl/motor_hbridge_driver.sv
// Multi-channel H-bridge driver: per-channel direction/PWM with dead-time on reversal
// and a global command watchdog that coasts every motor.
//
// state   | meaning
// RUN     | applied direction drives the bridge, new commands take effect next cycle
// DEAD    | forced coast after a fwd<->rev reversal, waiting DEAD_CYCLES before applying pending dir
module motor_hbridge_driver #(
    parameter int N_CH           = 2,
    parameter int PWM_W          = 8,
    parameter int PRESC          = 4,
    parameter int DEAD_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*N_CH-1:0]     cmd_dir,
    input  logic [PWM_W*N_CH-1:0] cmd_duty,
    input  logic                  cmd_valid,
    output logic [2*N_CH-1:0]     motor_in,
    output logic [N_CH-1:0]       motor_en,
    output logic [N_CH-1:0]       busy,
    output logic                  timeout
);

    localparam int PR_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int DC_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    logic [PR_W-1:0]  r_presc;
    logic [PWM_W-1:0] r_cnt;
    logic             w_tick;
    logic             w_wrap;

    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_timeout;
    logic             w_trip;

    logic [1:0]       w_ch_in   [N_CH];
    logic             w_ch_en   [N_CH];
    logic             w_ch_busy [N_CH];

    assign w_tick = (r_presc == '0);
    assign w_wrap = w_tick && (r_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= PR_W'(PRESC - 1);
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_presc <= r_presc - 1'b1;
            end
        end
    end

    // A command landing on the trip cycle wins, so the trip is suppressed.
    assign w_trip = WD_EN && !cmd_valid && !r_timeout &&
                    (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (cmd_valid) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_trip) begin
            r_timeout <= 1'b1;
        end else if (WD_EN && !r_timeout) begin
            r_wd_cnt  <= r_wd_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [1:0]       w_cmd_dir;
        logic [PWM_W-1:0] w_cmd_duty;
        logic [1:0]       w_pend_dir_nxt;
        logic             w_rev;
        logic [1:0]       r_pend_dir;
        logic [PWM_W-1:0] r_pend_duty;
        logic [1:0]       r_app_dir;
        logic [PWM_W-1:0] r_act_duty;
        logic [0:0]       r_state;
        logic [DC_W-1:0]  r_dead_cnt;
        logic             r_pwm;

        assign w_cmd_dir      = cmd_dir[2*k +: 2];
        assign w_cmd_duty     = cmd_duty[PWM_W*k +: PWM_W];
        assign w_pend_dir_nxt = cmd_valid ? w_cmd_dir : r_pend_dir;
        assign w_rev          = ((r_app_dir == DIR_FWD) && (w_cmd_dir == DIR_REV)) ||
                                ((r_app_dir == DIR_REV) && (w_cmd_dir == DIR_FWD));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend_dir  <= DIR_COAST;
                r_pend_duty <= '0;
            end else if (cmd_valid) begin
                r_pend_dir  <= w_cmd_dir;
                r_pend_duty <= w_cmd_duty;
            end else if (w_trip) begin
                r_pend_dir  <= DIR_COAST;
            end
        end

        // Applied dir is parked at coast while in DEAD so the pin decode needs no state term.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_RUN;
                r_app_dir  <= DIR_COAST;
                r_dead_cnt <= '0;
            end else if (w_trip) begin
                r_state    <= ST_RUN;
                r_app_dir  <= DIR_COAST;
                r_dead_cnt <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (cmd_valid) begin
                            if (w_rev) begin
                                r_state    <= ST_DEAD;
                                r_app_dir  <= DIR_COAST;
                                r_dead_cnt <= DC_W'(DEAD_CYCLES - 1);
                            end else begin
                                r_app_dir  <= w_cmd_dir;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (r_dead_cnt == '0) begin
                            r_state   <= ST_RUN;
                            r_app_dir <= w_pend_dir_nxt;
                        end else begin
                            r_dead_cnt <= r_dead_cnt - 1'b1;
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act_duty <= '0;
                r_pwm      <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_act_duty <= r_pend_duty;
                end
                r_pwm <= (r_cnt < r_act_duty);
            end
        end

        always_comb begin
            w_ch_en[k] = 1'b0;
            case (r_app_dir)
                DIR_FWD, DIR_REV: w_ch_en[k] = r_pwm && (r_state == ST_RUN);
                DIR_BRAKE:        w_ch_en[k] = (r_state == ST_RUN);
                default:          w_ch_en[k] = 1'b0;
            endcase
        end

        assign w_ch_in[k]   = r_app_dir;
        assign w_ch_busy[k] = (r_state == ST_DEAD);
    end

    always_comb begin
        motor_in = '0;
        motor_en = '0;
        busy     = '0;
        for (int k = 0; k < N_CH; k++) begin
            motor_in[2*k +: 2] = w_ch_in[k];
            motor_en[k]        = w_ch_en[k];
            busy[k]            = w_ch_busy[k];
        end
    end

    assign timeout = r_timeout;

endmodule
